// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads the program ROM, resolves unconditional branches
// locally and hands every other instruction to the execute stage via valid/ready.
module instr_fetch_unit #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int ROM_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_chip_select,
    input  logic [DATA_W-1:0] rom_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [3:0]        opcode,
    output logic [15:0]       operand,
    output logic [ADDR_W-1:0] pc_out,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              halt,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECODE = 2'd2,
        ST_ISSUE  = 2'd3
    } state_t;

    localparam logic [2:0]        WAIT_LAST = 3'(ROM_WAIT - 1);
    localparam logic [3:0]        OP_BRANCH = 4'd8;
    localparam logic [ADDR_W-1:0] PC_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] pc_r, pc_s;
    logic [3:0]        opcode_r, opcode_s;
    logic [15:0]       operand_r, operand_s;
    logic [2:0]        wait_cnt_r, wait_cnt_s;
    logic [ADDR_W-1:0] rom_address_r, rom_address_s;
    logic [ADDR_W-1:0] pc_out_r, pc_out_s;
    logic              valid_r;
    logic              cs_r;
    logic              busy_r;
    logic              unused_rom_bits_s;

    // Middle instruction bits carry no meaning for this machine.
    assign unused_rom_bits_s = ^rom_data[27:16];

    // Next-state and datapath updates; redirect outranks every other transition.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        opcode_s      = opcode_r;
        operand_s     = operand_r;
        wait_cnt_s    = wait_cnt_r;
        rom_address_s = rom_address_r;
        pc_out_s      = pc_out_r;
        case (state_r)
            ST_IDLE: begin
                if (redirect) begin
                    pc_s = redirect_addr;
                end else if (!halt) begin
                    state_s       = ST_FETCH;
                    wait_cnt_s    = 3'd0;
                    rom_address_s = pc_r;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                wait_cnt_s = wait_cnt_r + 3'd1;
                if (redirect) begin
                    pc_s    = redirect_addr;
                    state_s = ST_IDLE;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    opcode_s  = rom_data[31:28];
                    operand_s = rom_data[15:0];
                    pc_out_s  = pc_r;
                    state_s   = ST_DECODE;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (redirect) begin
                    pc_s    = redirect_addr;
                    state_s = ST_IDLE;
                end else if (opcode_r == OP_BRANCH) begin
                    pc_s    = operand_r[ADDR_W-1:0];
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (instr_ready) begin
                    pc_s    = redirect ? redirect_addr : (pc_r + PC_ONE);
                    state_s = ST_IDLE;
                end else if (redirect) begin
                    pc_s    = redirect_addr;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; outputs are decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            pc_r          <= '0;
            opcode_r      <= 4'd0;
            operand_r     <= 16'd0;
            wait_cnt_r    <= 3'd0;
            rom_address_r <= '0;
            pc_out_r      <= '0;
            valid_r       <= 1'b0;
            cs_r          <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            opcode_r      <= opcode_s;
            operand_r     <= operand_s;
            wait_cnt_r    <= wait_cnt_s;
            rom_address_r <= rom_address_s;
            pc_out_r      <= pc_out_s;
            valid_r       <= (state_s == ST_ISSUE);
            cs_r          <= (state_s == ST_FETCH);
            busy_r        <= (state_s != ST_IDLE);
        end
    end

    assign rom_address     = rom_address_r;
    assign rom_chip_select = cs_r;
    assign instr_valid     = valid_r;
    assign opcode          = opcode_r;
    assign operand         = operand_r;
    assign pc_out          = pc_out_r;
    assign busy            = busy_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by a randomized run
// checked against a program-walk reference model.
module tb_instr_fetch_unit;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int RW = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] rom_address;
    logic          rom_chip_select;
    logic [DW-1:0] rom_data;
    logic          instr_valid;
    logic          instr_ready;
    logic [3:0]    opcode;
    logic [15:0]   operand;
    logic [AW-1:0] pc_out;
    logic          redirect;
    logic [AW-1:0] redirect_addr;
    logic          halt;
    logic          busy;

    logic [31:0] rom [32];
    logic        cs_before;
    int          n_checks = 0;
    int          n_errors = 0;

    instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .ROM_WAIT(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rom_address(rom_address), .rom_chip_select(rom_chip_select), .rom_data(rom_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .operand(operand), .pc_out(pc_out),
        .redirect(redirect), .redirect_addr(redirect_addr),
        .halt(halt), .busy(busy)
    );

    always #5 clk = ~clk;
    assign rom_data = rom[rom_address];

    // Chip select as it was before the most recent edge, for rise detection.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cs_before <= 1'b0;
        else        cs_before <= rom_chip_select;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_fetch(input string tag, output logic [AW-1:0] addr, output int nvalid);
        bit found;
        found  = 1'b0;
        nvalid = 0;
        addr   = '0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (instr_valid) nvalid++;
            if (rom_chip_select && !cs_before) begin
                found = 1'b1;
                addr  = rom_address;
            end
        end
        if (!found) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 60 && !instr_valid; i++) @(negedge clk);
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        int            nv;
        logic [AW-1:0] model_pc;
        logic [24:0]   issue_q[$];
        logic [24:0]   held, exp_issue;
        logic          hold;
        logic [31:0]   word;
        int            cs_len, n_issue, j;
        bit            ok;

        for (int i = 0; i < 32; i++) rom[i] = {4'h2, 12'h000, 16'(i)};
        rom[0]  = 32'h4000_000F;
        rom[3]  = 32'h1000_005F;
        rom[12] = 32'h4000_F0F0;
        rom[20] = 32'h8000_0000;
        rom[31] = 32'h6000_1234;

        rst_n = 1'b0; instr_ready = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_addr = '0;
        #12;
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_cs", {31'd0, rom_chip_select}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_addr", 32'(rom_address), 32'd0);
        check("rst_opcode", 32'(opcode), 32'd0);
        check("rst_operand", 32'(operand), 32'd0);
        check("rst_pc_out", 32'(pc_out), 32'd0);

        // First fetch latency after reset release.
        @(negedge clk); rst_n = 1'b1; instr_ready = 1'b1;
        @(negedge clk);
        check("e1_cs", {31'd0, rom_chip_select}, 32'd1);
        check("e1_addr", 32'(rom_address), 32'd0);
        check("e1_busy", {31'd0, busy}, 32'd1);
        check("e1_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        check("e2_cs", {31'd0, rom_chip_select}, 32'd0);
        check("e2_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        check("e3_valid", {31'd0, instr_valid}, 32'd1);
        check("e3_opcode", 32'(opcode), 32'd4);
        check("e3_operand", 32'(operand), 32'h000F);
        check("e3_pc_out", 32'(pc_out), 32'd0);
        wait_fetch("t1_next", a, nv);
        check("t1_next_addr", 32'(a), 32'd1);

        // Backpressure on address 3.
        instr_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wait_valid("t2_pre");
            instr_ready = 1'b1;
            @(negedge clk);
            instr_ready = 1'b0;
        end
        wait_valid("t2");
        check("t2_pc_out", 32'(pc_out), 32'd3);
        check("t2_opcode", 32'(opcode), 32'd1);
        check("t2_operand", 32'(operand), 32'h005F);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t2_hold_valid", {31'd0, instr_valid}, 32'd1);
            check("t2_hold_op", {opcode, operand, 7'd0, pc_out}, {4'd1, 16'h005F, 7'd0, 5'd3});
            check("t2_hold_cs", {31'd0, rom_chip_select}, 32'd0);
        end
        instr_ready = 1'b1;
        wait_fetch("t2_next", a, nv);
        check("t2_next_addr", 32'(a), 32'd4);

        // Branch at 0x14 back to 0.
        redirect = 1'b1; redirect_addr = 5'h14;
        @(negedge clk); redirect = 1'b0;
        wait_fetch("t3_br", a, nv);
        check("t3_br_addr", 32'(a), 32'h14);
        wait_fetch("t3_tgt", a, nv);
        check("t3_tgt_addr", 32'(a), 32'd0);
        check("t3_no_valid", 32'(nv), 32'd0);
        wait_valid("t3_issue");
        check("t3_issue", {opcode, operand, 7'd0, pc_out}, {4'd4, 16'h000F, 7'd0, 5'd0});

        // Redirect during the fetch of address 5.
        ok = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            wait_fetch("t5_seek", a, nv);
            ok = (a == 5'd5);
        end
        check("t5_seek_found", {31'd0, ok}, 32'd1);
        redirect = 1'b1; redirect_addr = 5'h0C;
        @(negedge clk); redirect = 1'b0;
        wait_fetch("t5_tgt", a, nv);
        check("t5_tgt_addr", 32'(a), 32'h0C);
        wait_valid("t5_issue");
        check("t5_issue", {opcode, operand, 7'd0, pc_out}, {4'd4, 16'hF0F0, 7'd0, 5'h0C});

        // Redirect coinciding with a completed handshake, then wrap from 31.
        redirect = 1'b1; redirect_addr = 5'd31;
        @(negedge clk); redirect = 1'b0;
        wait_fetch("t4_31", a, nv);
        check("t4_31_addr", 32'(a), 32'd31);
        wait_valid("t4_issue");
        check("t4_issue", {opcode, operand, 7'd0, pc_out}, {4'd6, 16'h1234, 7'd0, 5'd31});
        wait_fetch("t4_wrap", a, nv);
        check("t4_wrap_addr", 32'(a), 32'd0);

        // Squash in ISSUE without ready.
        instr_ready = 1'b0;
        wait_valid("sq_pre");
        redirect = 1'b1; redirect_addr = 5'd3;
        @(negedge clk); redirect = 1'b0;
        check("sq_valid_drop", {31'd0, instr_valid}, 32'd0);
        wait_fetch("sq_tgt", a, nv);
        check("sq_tgt_addr", 32'(a), 32'd3);
        wait_valid("sq_issue");
        check("sq_pc_out", 32'(pc_out), 32'd3);

        // Asynchronous reset in ISSUE.
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, instr_valid}, 32'd0);
        check("arst_cs", {31'd0, rom_chip_select}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk); rst_n = 1'b1; instr_ready = 1'b1;
        wait_fetch("arst_restart", a, nv);
        check("arst_restart_addr", 32'(a), 32'd0);

        // Halt raised mid-fetch.
        halt = 1'b1;
        wait_valid("halt_issue");
        check("halt_issue_pc", 32'(pc_out), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("halt_idle", {30'd0, busy, rom_chip_select}, 32'd0);
        end
        halt = 1'b0;
        wait_fetch("halt_resume", a, nv);
        check("halt_resume_addr", 32'(a), 32'd1);

        // Randomized run against a program-walk model.
        rst_n = 1'b0; instr_ready = 1'b0;
        for (int i = 0; i < 32; i++)
            rom[i] = {4'($urandom_range(0, 15)), 12'($urandom), 16'($urandom)};
        for (int i = 0; i < 32; i++) begin
            if (rom[i][31:28] == 4'd8) begin
                ok = 1'b0;
                for (int t = 0; t < 32 && !ok; t++) begin
                    j = $urandom_range(0, 31);
                    if (rom[j][31:28] != 4'd8) begin
                        rom[i][4:0] = 5'(j);
                        ok = 1'b1;
                    end
                end
                if (!ok) rom[i][31:28] = 4'd3;
            end
        end
        @(negedge clk); rst_n = 1'b1;
        model_pc = '0; hold = 1'b0; held = '0; cs_len = 0; n_issue = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (rom_chip_select) begin
                if (!cs_before) begin
                    check("rand_fetch_addr", 32'(rom_address), 32'(model_pc));
                    word = rom[model_pc];
                    if (word[31:28] == 4'd8) begin
                        model_pc = word[4:0];
                    end else begin
                        issue_q.push_back({word[31:28], word[15:0], model_pc});
                        model_pc = model_pc + 5'd1;
                    end
                end
                cs_len++;
            end else if (cs_len != 0) begin
                check("rand_cs_len", 32'(cs_len), 32'(RW));
                cs_len = 0;
            end
            if (hold) begin
                check("rand_hold", {6'd0, instr_valid, opcode, operand, pc_out}, {6'd0, 1'b1, held});
            end
            if (instr_valid) begin
                instr_ready = ($urandom_range(0, 2) != 0);
                if (instr_ready) begin
                    exp_issue = (issue_q.size() > 0) ? issue_q.pop_front() : 25'h1FFFFFF;
                    check("rand_issue", {7'd0, opcode, operand, pc_out}, {7'd0, exp_issue});
                    n_issue++;
                    hold = 1'b0;
                end else begin
                    hold = 1'b1;
                    held = {opcode, operand, pc_out};
                end
            end else begin
                instr_ready = 1'($urandom_range(0, 1));
                hold = 1'b0;
            end
            halt = ($urandom_range(0, 9) == 0);
        end
        check("rand_issue_count_nonzero", {31'd0, (n_issue > 50)}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
